// File: rtl/audio_pkg.sv
// Types and constants shared by the audio playback path
// (flash prefetcher and codec write stage).
package audio_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam logic [FLASH_ADDR_W-1:0] NUM_WORDS_DEFAULT = 23'h100000;

  typedef enum logic [1:0] {
    SPD_NORMAL = 2'b00,
    SPD_FAST   = 2'b01,
    SPD_SLOW   = 2'b10
  } speed_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_DATA  = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  // Word-address increment for one advance; slow mode fetches each word twice.
  function automatic logic [1:0] addr_step(input logic [1:0] speed, input logic rep_flag);
    logic [1:0] step;
    case (speed)
      SPD_FAST: step = 2'd2;
      SPD_SLOW: step = rep_flag ? 2'd1 : 2'd0;
      default:  step = 2'd1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered write, show-ahead head, occupancy count and
// synchronous flush. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && (r_count != CNT_FULL) && !flush;
  assign w_pop  = pop && (r_count != '0) && !flush;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/flash_sample_prefetcher.sv
// Avalon-MM read master that prefetches 32-bit flash words into a FIFO and
// streams them as 16-bit samples, low half first.
module flash_sample_prefetcher
  import audio_pkg::*;
#(
  parameter int                ADDR_W     = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] NUM_WORDS  = ADDR_W'(NUM_WORDS_DEFAULT),
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              enable,
  input  logic              restart,
  input  logic [1:0]        speed,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              wrap
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_read;
  logic              w_read_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_rep;
  logic              w_rep_nxt;
  logic              r_wrap;
  logic              w_wrap_nxt;
  logic              r_pend_rst;
  logic              w_pend_rst_nxt;
  logic              r_half;
  logic              w_push;
  logic              w_hs;
  logic              w_pop;
  logic [31:0]       w_head;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [1:0]        w_step;
  logic [ADDR_W:0]   w_adv_sum;
  logic              w_adv_wrap;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetb),
    .flush     (restart),
    .push      (w_push),
    .push_data (flash_mem_readdata),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign w_step     = addr_step(speed, r_rep);
  assign w_adv_sum  = {1'b0, r_addr} + {{(ADDR_W - 1){1'b0}}, w_step};
  assign w_adv_wrap = (w_adv_sum >= {1'b0, NUM_WORDS});

  // Next-state and next-register values for the read master.
  always_comb begin
    w_state_nxt    = r_state;
    w_read_nxt     = r_read;
    w_addr_nxt     = r_addr;
    w_rep_nxt      = r_rep;
    w_wrap_nxt     = 1'b0;
    w_pend_rst_nxt = r_pend_rst;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (restart) begin
          w_addr_nxt = '0;
          w_rep_nxt  = 1'b0;
        end else if (enable && (w_count < DEPTH_CNT)) begin
          w_state_nxt = S_REQ;
          w_read_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      // Address must stay stable while the command is pending, so a restart
      // seen here only clears the address once the command is accepted.
      S_REQ: begin
        if (!flash_mem_waitrequest) begin
          w_read_nxt = 1'b0;
          if (restart || r_pend_rst) begin
            w_state_nxt    = S_DRAIN;
            w_addr_nxt     = '0;
            w_rep_nxt      = 1'b0;
            w_pend_rst_nxt = 1'b0;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else if (restart) begin
          w_pend_rst_nxt = 1'b1;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DATA: begin
        if (restart) begin
          w_addr_nxt  = '0;
          w_rep_nxt   = 1'b0;
          w_state_nxt = flash_mem_readdatavalid ? S_IDLE : S_DRAIN;
        end else if (flash_mem_readdatavalid) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
          w_rep_nxt   = (speed == SPD_SLOW) ? ~r_rep : 1'b0;
          if (w_adv_wrap) begin
            w_addr_nxt = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_addr_nxt = w_adv_sum[ADDR_W-1:0];
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_DRAIN: begin
        if (flash_mem_readdatavalid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_read_nxt  = 1'b0;
      end
    endcase
  end

  // Read-master state and registered Avalon outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state    <= S_IDLE;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_rep      <= 1'b0;
      r_wrap     <= 1'b0;
      r_pend_rst <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_read     <= w_read_nxt;
      r_addr     <= w_addr_nxt;
      r_rep      <= w_rep_nxt;
      r_wrap     <= w_wrap_nxt;
      r_pend_rst <= w_pend_rst_nxt;
    end
  end

  assign w_hs  = !w_empty && sample_ready;
  assign w_pop = w_hs && r_half;

  // Half-select: low half first, the MSB handshake retires the word.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_half <= 1'b0;
    end else if (restart) begin
      r_half <= 1'b0;
    end else if (w_hs) begin
      r_half <= ~r_half;
    end else begin
      r_half <= r_half;
    end
  end

  assign flash_mem_read    = r_read;
  assign flash_mem_address = r_addr;
  assign wrap              = r_wrap;
  assign sample_valid      = !w_empty;
  assign sample_data       = w_empty ? 16'h0000 : (r_half ? w_head[31:16] : w_head[15:0]);

endmodule
